// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable SEQ_LEN-bit pattern, optional overlap,
// a toggle flag and a saturating match counter; all outputs come straight from flops.
module seq_detect_param #(
    parameter int SEQ_LEN = 5,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               cfg_load,
    input  logic [SEQ_LEN-1:0] cfg_pattern,
    input  logic               signal_vld,
    input  logic               signal_in,
    output logic               match_pulse,
    output logic               match_flag,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] pattern;
    logic [SEQ_LEN-1:0] hist;
    logic [SEQ_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;
    logic               match;

    // signal_vld is a one-way qualifier (no back-pressure): a beat is consumed on
    // every edge where it is high, unless clr or cfg_load claims that edge.
    always_comb begin
        hist_next = {hist[SEQ_LEN-2:0], signal_in};
        fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match     = signal_vld && !clr && !cfg_load &&
                    (fill_next == FILL_FULL) && (hist_next == pattern);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern     <= '0;
            hist        <= '0;
            fill        <= '0;
            match_pulse <= 1'b0;
            match_flag  <= 1'b0;
            match_cnt   <= '0;
        end else if (clr) begin
            if (cfg_load) begin
                pattern <= cfg_pattern;
            end
            hist        <= '0;
            fill        <= '0;
            match_pulse <= 1'b0;
            match_flag  <= 1'b0;
            match_cnt   <= '0;
        end else if (cfg_load) begin
            // The beat on a load edge is dropped; history is kept but must refill.
            pattern     <= cfg_pattern;
            fill        <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= match;
            if (signal_vld) begin
                hist <= hist_next;
                fill <= (match && OVERLAP == 0) ? '0 : fill_next;
            end
            if (match) begin
                match_flag <= ~match_flag;
                if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: an overlapping 5-bit instance and a
// non-overlapping 4-bit instance with a 2-bit counter.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: SEQ_LEN=5, OVERLAP=1, CNT_W=8
    logic       a_clr, a_load, a_vld, a_in;
    logic [4:0] a_pat;
    logic       a_pulse, a_flag;
    logic [7:0] a_cnt;

    // Instance B: SEQ_LEN=4, OVERLAP=0, CNT_W=2
    logic       b_clr, b_load, b_vld, b_in;
    logic [3:0] b_pat;
    logic       b_pulse, b_flag;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.SEQ_LEN(5), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .clr(a_clr), .cfg_load(a_load), .cfg_pattern(a_pat),
        .signal_vld(a_vld), .signal_in(a_in),
        .match_pulse(a_pulse), .match_flag(a_flag), .match_cnt(a_cnt)
    );

    seq_detect_param #(.SEQ_LEN(4), .OVERLAP(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .cfg_load(b_load), .cfg_pattern(b_pat),
        .signal_vld(b_vld), .signal_in(b_in),
        .match_pulse(b_pulse), .match_flag(b_flag), .match_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already set, outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        a_clr = 1'b0; a_load = 1'b0; a_vld = 1'b0;
        b_clr = 1'b0; b_load = 1'b0; b_vld = 1'b0;
    endtask

    task automatic a_bit(input logic b);
        a_vld = 1'b1; a_in = b;
        tick();
    endtask

    task automatic b_bit(input logic b);
        b_vld = 1'b1; b_in = b;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] a_str9, a_exp9;
        logic [6:0] a_str7, a_exp7;
        logic [3:0] b_str;
        logic [5:0] b_str6, b_exp6;
        logic [1:0] exp_cnt;

        rst = 1'b1;
        a_clr = 0; a_load = 0; a_vld = 0; a_in = 0; a_pat = '0;
        b_clr = 0; b_load = 0; b_vld = 0; b_in = 0; b_pat = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_pulse", a_pulse, 0);
        check("rst_a_flag",  a_flag,  0);
        check("rst_a_cnt",   a_cnt,   0);
        check("rst_b_pulse", b_pulse, 0);
        check("rst_b_cnt",   b_cnt,   0);
        rst = 1'b0;

        // Reset pattern is 00000: the fifth zero is the first possible match.
        for (int i = 0; i < 5; i++) begin
            a_bit(1'b0);
            check("guard_pulse", a_pulse, (i == 4) ? 1 : 0);
        end
        check("guard_cnt",  a_cnt,  1);
        check("guard_flag", a_flag, 1);
        a_clr = 1'b1;
        tick();
        check("clr_pulse", a_pulse, 0);
        check("clr_cnt",   a_cnt,   0);
        check("clr_flag",  a_flag,  0);

        // Overlapping detection of 01000.
        a_load = 1'b1; a_pat = 5'b01000;
        tick();
        check("load_pulse", a_pulse, 0);
        a_str9 = 9'b010001000;
        a_exp9 = 9'b000010001;
        for (int i = 8; i >= 0; i--) begin
            a_bit(a_str9[i]);
            check("ovl_pulse", a_pulse, a_exp9[i]);
        end
        check("ovl_cnt",  a_cnt,  2);
        check("ovl_flag", a_flag, 0);

        // Reload after a partial 010: the old partial must not complete.
        a_bit(0); check("pre_load_pulse", a_pulse, 0);
        a_bit(1); check("pre_load_pulse", a_pulse, 0);
        a_bit(0); check("pre_load_pulse", a_pulse, 0);
        a_load = 1'b1; a_pat = 5'b01000; a_vld = 1'b1; a_in = 1'b0;
        tick();
        check("load_beat_pulse", a_pulse, 0);
        a_str7 = 7'b0001000;
        a_exp7 = 7'b0000001;
        for (int i = 6; i >= 0; i--) begin
            a_bit(a_str7[i]);
            check("reload_pulse", a_pulse, a_exp7[i]);
        end
        check("reload_cnt",  a_cnt,  3);
        check("reload_flag", a_flag, 1);

        // clr on the final matching bit suppresses the match; pattern survives.
        a_bit(0); a_bit(1); a_bit(0); a_bit(0);
        check("pre_clr_pulse", a_pulse, 0);
        a_clr = 1'b1; a_vld = 1'b1; a_in = 1'b0;
        tick();
        check("clr_final_pulse", a_pulse, 0);
        check("clr_final_cnt",   a_cnt,   0);
        check("clr_final_flag",  a_flag,  0);
        a_str7 = 7'b0001000;
        for (int i = 4; i >= 0; i--) begin
            a_bit(a_str7[i]);
            check("post_clr_pulse", a_pulse, (i == 0) ? 1 : 0);
        end
        check("post_clr_cnt", a_cnt, 1);

        // Asynchronous reset mid-sequence, between clock edges.
        a_bit(0); a_bit(1); a_bit(0);
        #2 rst = 1'b1;
        #2;
        check("async_rst_cnt",   a_cnt,   0);
        check("async_rst_flag",  a_flag,  0);
        check("async_rst_pulse", a_pulse, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_bit(1'b0);
            check("post_rst_pulse", a_pulse, (i == 4) ? 1 : 0);
        end
        check("post_rst_cnt", a_cnt, 1);

        // Non-overlapping detection of 1010.
        b_load = 1'b1; b_pat = 4'b1010;
        tick();
        b_str6 = 6'b101010;
        b_exp6 = 6'b000100;
        for (int i = 5; i >= 0; i--) begin
            b_bit(b_str6[i]);
            check("novl_pulse", b_pulse, b_exp6[i]);
        end
        check("novl_cnt",  b_cnt,  1);
        check("novl_flag", b_flag, 1);

        // clr together with load: counter clears and the new pattern takes effect.
        b_clr = 1'b1; b_load = 1'b1; b_pat = 4'b1101;
        tick();
        check("clr_load_cnt",  b_cnt,  0);
        check("clr_load_flag", b_flag, 0);
        b_str = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            b_bit(b_str[i]);
            check("gap_pulse", b_pulse, (i == 0) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                b_vld = 1'b0; b_in = 1'($urandom_range(0, 1));
                tick();
                check("gap_idle_pulse", b_pulse, 0);
            end
        end
        check("gap_cnt", b_cnt, 1);

        // Saturation of the 2-bit counter over five matches.
        b_clr = 1'b1;
        tick();
        for (int m = 0; m < 5; m++) begin
            for (int i = 3; i >= 0; i--) begin
                b_bit(b_str[i]);
                check("sat_pulse", b_pulse, (i == 0) ? 1 : 0);
            end
            exp_cnt = (m >= 2) ? 2'd3 : 2'(m + 1);
            check("sat_cnt",  b_cnt,  exp_cnt);
            check("sat_flag", b_flag, (m % 2 == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
